// File: rtl/serial_addsub_32.sv
// Byte-serial 32-bit add/subtract: one 8-bit ripple slice reused over four
// cycles, LSB first, with carry/overflow/less-than/not-equal flags.
module serial_addsub_32 (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        op_sub,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic        busy,
    output logic        done,
    output logic [31:0] data_result,
    output logic        carry_out,
    output logic        overflow,
    output logic        isLessThan,
    output logic        isNotEqual
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [1:0]  k_q, k_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        op_q, op_d;
    logic        carry_q, carry_d;
    logic [31:0] result_q, result_d;
    logic        done_q, done_d;
    logic        cout_q, cout_d;
    logic        ovf_q, ovf_d;
    logic        lt_q, lt_d;
    logic        ne_q, ne_d;

    logic [7:0]  a_byte, b_byte;
    logic [8:0]  slice;
    logic        cin7;
    logic [31:0] merged;

    always_comb begin
        a_byte = 8'(a_q >> {k_q, 3'b000});
        b_byte = 8'(b_q >> {k_q, 3'b000});
        slice  = {1'b0, a_byte} + {1'b0, b_byte} + {8'b0, carry_q};
        // carry into the slice MSB, recovered from the sum bit
        cin7   = slice[7] ^ a_byte[7] ^ b_byte[7];
        merged = result_q;
        for (int i = 0; i < 4; i++) begin
            if (k_q == 2'(i)) merged[8*i +: 8] = slice[7:0];
        end

        state_d  = state_q;
        k_d      = k_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        carry_d  = carry_q;
        result_d = result_q;
        done_d   = 1'b0;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        lt_d     = lt_q;
        ne_d     = ne_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d      = data_operandA;
                    b_d      = op_sub ? ~data_operandB : data_operandB;
                    op_d     = op_sub;
                    carry_d  = op_sub;
                    k_d      = 2'd0;
                    state_d  = RUN;
                    result_d = 32'd0;
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    lt_d     = 1'b0;
                    ne_d     = 1'b0;
                end
            end
            default: begin
                result_d = merged;
                carry_d  = slice[8];
                k_d      = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    cout_d  = slice[8];
                    ovf_d   = cin7 ^ slice[8];
                    lt_d    = op_q & (slice[7] ^ (cin7 ^ slice[8]));
                    ne_d    = op_q & (|merged);
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            k_q      <= 2'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            op_q     <= 1'b0;
            carry_q  <= 1'b0;
            result_q <= 32'd0;
            done_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            lt_q     <= 1'b0;
            ne_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            done_q   <= done_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            lt_q     <= lt_d;
            ne_q     <= ne_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = done_q;
    assign data_result = result_q;
    assign carry_out   = cout_q;
    assign overflow    = ovf_q;
    assign isLessThan  = lt_q;
    assign isNotEqual  = ne_q;
endmodule

// File: tb/tb_serial_addsub_32.sv
// Bench for serial_addsub_32: fixed vector table, random ops against an
// arithmetic reference model, and handshake/reset corner sequences.
module tb_serial_addsub_32;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
        logic        c;
        logic        ov;
        logic        lt;
        logic        ne;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        op_sub = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        busy, done, carry_out, overflow, isLessThan, isNotEqual;
    logic [31:0] data_result;

    int n_chk = 0;
    int n_fail = 0;

    serial_addsub_32 dut (
        .clock(clock), .reset_n(reset_n), .start(start), .op_sub(op_sub),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .busy(busy), .done(done), .data_result(data_result),
        .carry_out(carry_out), .overflow(overflow),
        .isLessThan(isLessThan), .isNotEqual(isNotEqual)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain 33-bit arithmetic and signed comparison.
    function automatic vec_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        vec_t v;
        logic [32:0] full;
        v.a = a; v.b = b; v.sub = sub;
        full = sub ? ({1'b0, a} + {1'b0, ~b} + 33'd1) : ({1'b0, a} + {1'b0, b});
        v.res = full[31:0];
        v.c   = full[32];
        if (sub) v.ov = (a[31] != b[31]) && (v.res[31] != a[31]);
        else     v.ov = (a[31] == b[31]) && (v.res[31] != a[31]);
        v.lt  = sub && ($signed(a) < $signed(b));
        v.ne  = sub && (a != b);
        return v;
    endfunction

    task automatic check_outputs(input string tag, input vec_t v);
        check({tag, " result"}, data_result, v.res);
        check({tag, " carry"}, 32'(carry_out), 32'(v.c));
        check({tag, " ovf"}, 32'(overflow), 32'(v.ov));
        check({tag, " lt"}, 32'(isLessThan), 32'(v.lt));
        check({tag, " ne"}, 32'(isNotEqual), 32'(v.ne));
    endtask

    task automatic run_op(input string tag, input vec_t v);
        int cyc;
        @(negedge clock);
        start = 1'b1; op_sub = v.sub; data_operandA = v.a; data_operandB = v.b;
        @(posedge clock); #1;
        check({tag, " busy"}, 32'(busy), 32'd1);
        @(negedge clock);
        start = 1'b0; data_operandA = $urandom; data_operandB = $urandom; op_sub = ~v.sub;
        cyc = 0;
        while (!done && cyc < 10) begin
            @(posedge clock); #1;
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'd4);
        check({tag, " busy@done"}, 32'(busy), 32'd0);
        check_outputs(tag, v);
        @(posedge clock); #1;
        check({tag, " done pulse"}, 32'(done), 32'd0);
        check({tag, " hold"}, data_result, v.res);
    endtask

    vec_t tbl[7];
    vec_t v1, v2;

    initial begin
        int ndone, cyc;
        tbl[0] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{32'd5,         32'd7,         1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[4] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0};

        #12;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset outputs", {data_result}, 32'd0);
        check("reset flags", {28'd0, carry_out, overflow, isLessThan, isNotEqual}, 32'd0);
        @(negedge clock); reset_n = 1'b1;

        for (int i = 0; i < 7; i++) run_op($sformatf("vec%0d", i), tbl[i]);

        for (int i = 0; i < 25; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom; rb = $urandom;
            if (i % 5 == 0) rb = ra;
            if (i % 7 == 0) ra = {ra[31], 31'(ra[31] ? 0 : 32'h7FFF_FFFF)};
            run_op($sformatf("rnd%0d", i), model(ra, rb, 1'($urandom_range(0, 1))));
        end

        // start held high through RUN with changing operands
        v1 = model(32'd1, 32'd2, 1'b0);
        @(negedge clock);
        start = 1'b1; op_sub = 1'b0; data_operandA = 32'd1; data_operandB = 32'd2;
        @(posedge clock);
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            data_operandA = $urandom; data_operandB = $urandom; op_sub = 1'($urandom);
            if (done) ndone++;
        end
        #1;
        if (done) ndone++;
        start = 1'b0;
        check_outputs("held", v1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            if (done) ndone++;
        end
        check("held done count", 32'(ndone), 32'd1);
        check("held result kept", data_result, v1.res);

        // back-to-back: second start sampled at the done edge
        v1 = model(32'hDEAD_BEEF, 32'h1111_1111, 1'b1);
        v2 = model(32'h0000_00FF, 32'h0000_0001, 1'b0);
        @(negedge clock);
        start = 1'b1; op_sub = v1.sub; data_operandA = v1.a; data_operandB = v1.b;
        @(posedge clock);
        @(negedge clock);
        op_sub = v2.sub; data_operandA = v2.a; data_operandB = v2.b;
        repeat (4) @(posedge clock);
        #1;
        check("b2b first done", 32'(done), 32'd1);
        check_outputs("b2b first", v1);
        @(posedge clock); #1;
        check("b2b done low", 32'(done), 32'd0);
        check("b2b second busy", 32'(busy), 32'd1);
        @(negedge clock); start = 1'b0;
        cyc = 0;
        while (!done && cyc < 10) begin
            @(posedge clock); #1;
            cyc++;
        end
        check("b2b second latency", 32'(cyc), 32'd4);
        check_outputs("b2b second", v2);

        // reset mid-run after an op that left flags set
        run_op("pre-reset", model(32'd5, 32'd7, 1'b1));
        @(negedge clock);
        start = 1'b1; op_sub = 1'b1; data_operandA = 32'h8000_0000; data_operandB = 32'd1;
        @(posedge clock);
        @(negedge clock); start = 1'b0;
        @(posedge clock);
        @(negedge clock); reset_n = 1'b0;
        #1;
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset result", data_result, 32'd0);
        check("midreset flags", {27'd0, done, carry_out, overflow, isLessThan, isNotEqual}, 32'd0);
        @(negedge clock); reset_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            if (done || busy) ndone++;
        end
        check("no done after reset", 32'(ndone), 32'd0);
        run_op("post-reset", model(32'h0000_0100, 32'h0000_0200, 1'b1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
